led_strip_scanner: RTL and testbench

//  Downstream consumer of the 512x24 dual-port colour RAM. On start, reads LED_COUNT
//  24-bit words from read addresses 0..LED_COUNT-1 and serialises each one, MSB first,

---
 rtl/led_strip_scanner_if.sv | 22 ++
 rtl/led_strip_scanner.sv | 157 +++++++++++++++
 tb/tb_led_strip_scanner.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_strip_scanner_if.sv
// Read-side port of the 512x24 colour RAM as seen by the LED strip scanner.
// The scanner drives the strobe and address; the RAM answers one clock later.
interface led_strip_scanner_if;
  logic        perform_read;
  logic [8:0]  read_address;
  logic [23:0] read_data;
  logic        read_data_ready;

  modport master (
    output perform_read,
    output read_address,
    input  read_data,
    input  read_data_ready
  );

  modport slave (
    input  perform_read,
    input  read_address,
    output read_data,
    output read_data_ready
  );
endinterface

// File: rtl/led_strip_scanner.sv
// Streams LED_COUNT 24-bit words from the colour RAM onto a WS2812-style NRZ line,
// prefetching the next word during bit 23 so words follow each other without a gap.
module led_strip_scanner #(
  parameter int LED_COUNT = 64,
  parameter int T0H       = 5,
  parameter int T1H       = 10,
  parameter int T_BIT     = 15,
  parameter int T_RESET   = 960
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic dout,
  led_strip_scanner_if.master ram
);
  localparam int PH_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int LT_W = $clog2(T_RESET + 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(T_BIT - 1);
  localparam logic [LT_W-1:0] LT_LAST   = LT_W'(T_RESET - 1);
  localparam logic [8:0]      WORD_LAST = 9'(LED_COUNT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, LATCH} state_t;

  state_t          r_state, w_state_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic [4:0]      r_bitcnt, w_bitcnt_nxt;
  logic [8:0]      r_word, w_word_nxt;
  logic [LT_W-1:0] r_latch, w_latch_nxt;
  logic [23:0]     r_shift, w_shift_nxt;
  logic [23:0]     r_hold, w_hold_nxt;
  logic            r_outstanding, w_outstanding_nxt;
  logic            r_read, w_read_nxt;
  logic [8:0]      r_addr, w_addr_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_dout, w_dout_nxt;
  logic            w_capture;

  assign ram.perform_read = r_read;
  assign ram.read_address = r_addr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign dout             = r_dout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_bitcnt_nxt = r_bitcnt;
    w_word_nxt   = r_word;
    w_latch_nxt  = r_latch;
    w_shift_nxt  = r_shift;
    w_hold_nxt   = r_hold;
    w_done_nxt   = 1'b0;
    w_read_nxt   = 1'b0;
    w_addr_nxt   = r_addr;
    // Data is only accepted in the cycle after a strobe; stray ready pulses are dropped.
    w_capture         = ram.read_data_ready && r_outstanding;
    w_outstanding_nxt = (r_outstanding && !w_capture) || r_read;

    unique case (r_state)
      IDLE: if (start) w_state_nxt = FETCH;
      FETCH: begin
        w_state_nxt = WAIT;
        w_read_nxt  = 1'b1;
        w_addr_nxt  = '0;
      end
      WAIT: if (w_capture) begin
        w_shift_nxt  = ram.read_data;
        w_bitcnt_nxt = 5'd23;
        w_phase_nxt  = '0;
        w_word_nxt   = '0;
        w_state_nxt  = SHIFT;
      end
      SHIFT: begin
        if (w_capture) w_hold_nxt = ram.read_data;
        if (r_phase != PH_LAST) begin
          w_phase_nxt = r_phase + 1'b1;
        end else begin
          w_phase_nxt = '0;
          if (r_bitcnt != '0) begin
            w_shift_nxt  = {r_shift[22:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end else if (r_word == WORD_LAST) begin
            w_latch_nxt = '0;
            w_state_nxt = LATCH;
          end else begin
            w_shift_nxt  = r_hold;
            w_bitcnt_nxt = 5'd23;
            w_word_nxt   = r_word + 9'd1;
          end
        end
      end
      LATCH: begin
        if (r_latch == LT_LAST) begin
          // A start already pending at frame end chains the next frame directly.
          w_done_nxt  = 1'b1;
          w_state_nxt = start ? FETCH : IDLE;
        end else begin
          w_latch_nxt = r_latch + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Prefetch strobe lands in the first cycle of bit 23 of every word but the last.
    if (w_state_nxt == SHIFT && w_phase_nxt == '0 && w_bitcnt_nxt == 5'd23 &&
        r_state != WAIT && w_word_nxt != WORD_LAST) begin
      w_read_nxt = 1'b1;
      w_addr_nxt = w_word_nxt + 9'd1;
    end else if (r_state == WAIT && w_state_nxt == SHIFT && WORD_LAST != 9'd0) begin
      w_read_nxt = 1'b1;
      w_addr_nxt = 9'd1;
    end

    w_busy_nxt = (w_state_nxt != IDLE) && !w_done_nxt;
    w_dout_nxt = (w_state_nxt == SHIFT) &&
                 (int'(w_phase_nxt) < (w_shift_nxt[23] ? T1H : T0H));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase       <= '0;
      r_bitcnt      <= '0;
      r_word        <= '0;
      r_latch       <= '0;
      r_outstanding <= 1'b0;
      r_read        <= 1'b0;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_dout        <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_word        <= w_word_nxt;
      r_latch       <= w_latch_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_read        <= w_read_nxt;
      r_addr        <= w_addr_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_dout        <= w_dout_nxt;
    end
  end

  always_ff @(posedge clock) begin
    r_shift <= w_shift_nxt;
    r_hold  <= w_hold_nxt;
  end
endmodule

// File: tb/tb_led_strip_scanner.sv
// Bench for led_strip_scanner: three instances (2 LEDs, 1 LED, 512 LEDs with short
// timing) against a waveform reference computed from word/bit/phase arithmetic.
module tb_led_strip_scanner;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic st_a, st_b, st_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, dout_a, dout_b, dout_c;
  logic [23:0] mem [3][512];
  int n_checks = 0;
  int n_err    = 0;

  led_strip_scanner_if ifa ();
  led_strip_scanner_if ifb ();
  led_strip_scanner_if ifc ();

  led_strip_scanner #(.LED_COUNT(2)) u_a (
    .clock(clock), .reset_n(reset_n), .start(st_a), .busy(busy_a), .done(done_a),
    .dout(dout_a), .ram(ifa.master));
  led_strip_scanner #(.LED_COUNT(1)) u_b (
    .clock(clock), .reset_n(reset_n), .start(st_b), .busy(busy_b), .done(done_b),
    .dout(dout_b), .ram(ifb.master));
  led_strip_scanner #(.LED_COUNT(512), .T0H(1), .T1H(2), .T_BIT(3), .T_RESET(4)) u_c (
    .clock(clock), .reset_n(reset_n), .start(st_c), .busy(busy_c), .done(done_c),
    .dout(dout_c), .ram(ifc.master));

  // RAM models: one-clock read latency plus occasional stray ready pulses with junk data.
  always @(posedge clock) begin
    ifa.read_data_ready <= ifa.perform_read | ($urandom_range(0, 7) == 0);
    ifa.read_data       <= ifa.perform_read ? mem[0][ifa.read_address] : 24'($urandom);
    ifb.read_data_ready <= ifb.perform_read | ($urandom_range(0, 7) == 0);
    ifb.read_data       <= ifb.perform_read ? mem[1][ifb.read_address] : 24'($urandom);
    ifc.read_data_ready <= ifc.perform_read | ($urandom_range(0, 7) == 0);
    ifc.read_data       <= ifc.perform_read ? mem[2][ifc.read_address] : 24'($urandom);
  end

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       dout;
    logic       pr;
    logic [8:0] addr;
  } obs_t;

  function automatic obs_t obs(input int s);
    obs_t o;
    case (s)
      0:       o = '{busy_a, done_a, dout_a, ifa.perform_read, ifa.read_address};
      1:       o = '{busy_b, done_b, dout_b, ifb.perform_read, ifb.read_address};
      default: o = '{busy_c, done_c, dout_c, ifc.perform_read, ifc.read_address};
    endcase
    return o;
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       st_a = v;
      1:       st_b = v;
      default: st_c = v;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one frame on instance s and compares every cycle against the reference.
  // chained: the start edge already happened (previous frame's done edge).
  // hold: keep start high throughout. mid: cycle at which a stray start pulse is given.
  task automatic frame_check(input string tag, input int s, input int n, input int t0,
                             input int t1, input int tb, input int tr, input bit chained,
                             input bit hold, input int mid, output int longs,
                             output int shorts, output int nreads, output int last_addr,
                             output int done_cyc);
    obs_t o;
    int L, wbits, idx, w, b, ph, run;
    int bad_d, bad_b, bad_k, bad_r, fd, fb, fk, fr;
    logic ed, eb, ek, ep;
    int ea;
    L = 3 + n * 24 * tb + tr;
    wbits = 24 * tb;
    longs = 0; shorts = 0; nreads = 0; last_addr = -1; done_cyc = -1; run = 0;
    bad_d = 0; bad_b = 0; bad_k = 0; bad_r = 0; fd = -1; fb = -1; fk = -1; fr = -1;
    if (!chained) begin
      set_start(s, 1'b1);
      @(posedge clock); #1;
      if (!hold) set_start(s, 1'b0);
    end
    for (int c = 1; c <= L; c++) begin
      @(posedge clock); #1;
      o = obs(s);
      ed = 1'b0; ep = 1'b0; ea = 0;
      if (c >= 3 && c < 3 + n * wbits) begin
        idx = c - 3;
        w   = idx / wbits;
        b   = 23 - (idx % wbits) / tb;
        ph  = idx % tb;
        ed  = (ph < (mem[s][w][b] ? t1 : t0));
        if (idx % wbits == 0 && w < n - 1) begin ep = 1'b1; ea = w + 1; end
      end
      if (c == 1) begin ep = 1'b1; ea = 0; end
      ek = (c == L);
      eb = (c < L);
      if (o.dout !== ed) begin bad_d++; if (fd < 0) fd = c; end
      if (o.busy !== eb) begin bad_b++; if (fb < 0) fb = c; end
      if (o.done !== ek) begin bad_k++; if (fk < 0) fk = c; end
      if (o.pr !== ep || (ep && int'(o.addr) != ea)) begin bad_r++; if (fr < 0) fr = c; end
      if (o.dout) run++;
      else if (run > 0) begin
        if (run == t1) longs++;
        else if (run == t0) shorts++;
        run = 0;
      end
      if (o.pr) begin nreads++; last_addr = int'(o.addr); end
      if (o.done && done_cyc < 0) done_cyc = c;
      if (c == mid) set_start(s, 1'b1);
      else if (!hold) set_start(s, 1'b0);
    end
    chk($sformatf("%s dout waveform (first diff cycle %0d)", tag, fd), bad_d, 0);
    chk($sformatf("%s busy waveform (first diff cycle %0d)", tag, fb), bad_b, 0);
    chk($sformatf("%s done pulse (first diff cycle %0d)", tag, fk), bad_k, 0);
    chk($sformatf("%s read strobes (first diff cycle %0d)", tag, fr), bad_r, 0);
  endtask

  task automatic idle_check(input string tag, input int s, input int cycles);
    obs_t o;
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      o = obs(s);
      if (o.busy || o.done || o.dout || o.pr) act++;
    end
    chk($sformatf("%s idle activity", tag), act, 0);
  endtask

  typedef struct {
    logic [23:0] w0;
    logic [23:0] w1;
    int          exp_long;
    int          exp_short;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    obs_t o;
    int lg, sh, nr, la, dc;
    tbl[0] = '{24'hFF0000, 24'h000001, 9, 39};
    tbl[1] = '{24'h000000, 24'h000000, 0, 48};
    tbl[2] = '{24'hFFFFFF, 24'hFFFFFF, 48, 0};
    tbl[3] = '{24'hAAAAAA, 24'h555555, 24, 24};
    tbl[4] = '{24'h800000, 24'h000001, 2, 46};

    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    o = obs(0);
    chk("reset busy", int'(o.busy), 0);
    chk("reset done", int'(o.done), 0);
    chk("reset dout", int'(o.dout), 0);
    chk("reset perform_read", int'(o.pr), 0);
    chk("reset read_address", int'(o.addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_check("post-reset A", 0, 5);

    for (int i = 0; i < 5; i++) begin
      mem[0][0] = tbl[i].w0;
      mem[0][1] = tbl[i].w1;
      frame_check($sformatf("vec%0d", i), 0, 2, 5, 10, 15, 960, 1'b0, 1'b0, -1,
                  lg, sh, nr, la, dc);
      chk($sformatf("vec%0d long pulses", i), lg, tbl[i].exp_long);
      chk($sformatf("vec%0d short pulses", i), sh, tbl[i].exp_short);
      chk($sformatf("vec%0d reads", i), nr, 2);
      chk($sformatf("vec%0d done cycle", i), dc, 3 + 2 * 24 * 15 + 960);
    end

    mem[0][0] = 24'($urandom);
    mem[0][1] = 24'($urandom);
    frame_check("mid-start", 0, 2, 5, 10, 15, 960, 1'b0, 1'b0, 200, lg, sh, nr, la, dc);
    chk("mid-start pulse total", lg + sh, 48);
    idle_check("after mid-start", 0, 4);

    frame_check("held-1", 0, 2, 5, 10, 15, 960, 1'b0, 1'b1, -1, lg, sh, nr, la, dc);
    mem[0][0] = 24'($urandom);
    mem[0][1] = 24'($urandom);
    frame_check("held-2", 0, 2, 5, 10, 15, 960, 1'b1, 1'b0, -1, lg, sh, nr, la, dc);
    idle_check("after held", 0, 4);

    mem[1][0] = 24'($urandom);
    frame_check("single", 1, 1, 5, 10, 15, 960, 1'b0, 1'b0, -1, lg, sh, nr, la, dc);
    chk("single done cycle", dc, 1323);
    chk("single reads", nr, 1);

    for (int i = 0; i < 512; i++) mem[2][i] = 24'($urandom);
    set_start(2, 1'b1);
    @(posedge clock); #1;
    set_start(2, 1'b0);
    repeat (273) @(posedge clock);
    #1;
    o = obs(2);
    chk("pre-abort busy", int'(o.busy), 1);
    reset_n = 1'b0;
    #1;
    o = obs(2);
    chk("abort dout", int'(o.dout), 0);
    chk("abort busy", int'(o.busy), 0);
    chk("abort perform_read", int'(o.pr), 0);
    chk("abort read_address", int'(o.addr), 0);
    #2;
    reset_n = 1'b1;
    idle_check("after abort", 2, 20);

    frame_check("big", 2, 512, 1, 2, 3, 4, 1'b0, 1'b0, -1, lg, sh, nr, la, dc);
    chk("big reads", nr, 512);
    chk("big last address", la, 511);
    chk("big pulse total", lg + sh, 512 * 24);
    idle_check("after big", 2, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
